// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter_if
// Brief   : Requester byte handshakes, uart_tx_ctrl send/ready pair and status.
// Rev     : 1.0  initial release
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int DATA_W = 8
);
    logic              req0_valid;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              tx_send;
    logic [DATA_W-1:0] tx_data;
    logic              tx_ready;
    logic              grant_id;
    logic              busy;
    logic [15:0]       sent_count;
    logic              timeout_err;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, tx_ready,
        output req0_ready, req1_ready, tx_send, tx_data, grant_id, busy,
               sent_count, timeout_err
    );

    // Requester / UART / observer side
    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, tx_ready,
        input  req0_ready, req1_ready, tx_send, tx_data, grant_id, busy,
               sent_count, timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_arbiter
// Brief   : Round-robin sharing of one uart_tx_ctrl between two byte requesters.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_arbiter #(
    parameter int DATA_W       = 8,
    parameter int BUSY_TIMEOUT = 1023
) (
    input  wire logic        clk,
    input  wire logic        btnC_clr,
    uart_tx_arbiter_if.slave bus
);
    localparam int                 c_TMR_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_BUSY = 2'd2,
        S_WAIT_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic [DATA_W-1:0]  r_tx_data;
    logic               r_grant_id;
    logic               r_last_grant;
    logic               r_timeout_err;
    logic [15:0]        r_sent_count;
    logic [c_TMR_W-1:0] r_timer;

    logic               w_win_valid;
    logic               w_win_id;
    logic [DATA_W-1:0]  w_win_data;

    // On a tie the requester that did not own the last transfer wins.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = 1'b0;
        if (r_state == S_IDLE) begin
            if (bus.req0_valid && bus.req1_valid) begin
                w_win_valid = 1'b1;
                w_win_id    = ~r_last_grant;
            end else if (bus.req0_valid) begin
                w_win_valid = 1'b1;
                w_win_id    = 1'b0;
            end else if (bus.req1_valid) begin
                w_win_valid = 1'b1;
                w_win_id    = 1'b1;
            end
        end
    end

    assign w_win_data      = w_win_id ? bus.req1_data : bus.req0_data;
    assign bus.req0_ready  = w_win_valid && !w_win_id;
    assign bus.req1_ready  = w_win_valid &&  w_win_id;
    assign bus.tx_send     = (r_state == S_SEND) && bus.tx_ready;
    assign bus.tx_data     = r_tx_data;
    assign bus.grant_id    = r_grant_id;
    assign bus.busy        = (r_state != S_IDLE);
    assign bus.sent_count  = r_sent_count;
    assign bus.timeout_err = r_timeout_err;

    always_ff @(posedge clk or posedge btnC_clr) begin
        if (btnC_clr) begin
            r_state       <= S_IDLE;
            r_tx_data     <= '0;
            r_grant_id    <= 1'b0;
            r_last_grant  <= 1'b1;
            r_timeout_err <= 1'b0;
            r_sent_count  <= 16'd0;
            r_timer       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_tx_data  <= w_win_data;
                        r_grant_id <= w_win_id;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (bus.tx_ready) begin
                        r_timer <= '0;
                        r_state <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: begin
                    // A UART that never acknowledges the strobe must not lock up the arbiter.
                    if (!bus.tx_ready) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_timeout_err <= 1'b1;
                        r_last_grant  <= r_grant_id;
                        r_state       <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (bus.tx_ready) begin
                        r_sent_count <= r_sent_count + 16'd1;
                        r_last_grant <= r_grant_id;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_tx_arbiter
// Brief   : Directed and randomized checks of uart_tx_arbiter against a transfer-level model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int DATA_W       = 8;
    localparam int BUSY_TIMEOUT = 8;

    typedef struct packed {
        logic       id;
        logic [7:0] data;
    } xfer_t;

    logic clk = 1'b0;
    logic btnC_clr;

    uart_tx_arbiter_if #(.DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .DATA_W       (DATA_W),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk      (clk),
        .btnC_clr (btnC_clr),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int    n_checks = 0;
    int    n_errors = 0;
    xfer_t sent_q[$];
    xfer_t exp_q[$];
    int    m_last;

    // UART model controls
    bit    u_hold  = 1'b0;
    bit    u_never = 1'b0;
    int    u_lat   = 1;
    bit    u_drop  = 1'b0;
    int    u_cnt   = 0;
    bit    u_prev  = 1'b0;
    logic  u_s;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // uart_tx_ctrl stand-in: ready drops the cycle after a strobe for u_lat cycles.
    always @(negedge clk) begin
        if (btnC_clr) begin
            u_drop       = 1'b0;
            u_cnt        = 0;
            bus.tx_ready = !u_hold;
        end else if (u_hold) begin
            bus.tx_ready = 1'b0;
        end else if (u_drop) begin
            u_drop       = 1'b0;
            bus.tx_ready = 1'b0;
            u_cnt        = u_lat;
        end else if (u_cnt > 1) begin
            u_cnt--;
        end else begin
            u_cnt        = 0;
            bus.tx_ready = 1'b1;
        end
        #2;
        u_s = bus.tx_send;
        if (u_s === 1'b1) begin
            sent_q.push_back({bus.grant_id, bus.tx_data});
            chk("send_not_consecutive", {31'd0, u_prev}, 32'd0);
            if (!u_never && !btnC_clr) u_drop = 1'b1;
        end
        u_prev = (u_s === 1'b1);
    end

    function automatic int winner(input bit v0, input bit v1, input int last);
        if (v0 && v1) return (last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        btnC_clr       = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        repeat (2) tick();
        btnC_clr = 1'b0;
        m_last   = 1;
        sent_q.delete();
        exp_q.delete();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.busy !== 1'b0 && n < budget) begin
            tick();
            #1;
            n++;
        end
        chk({tag, "_idle_bound"}, {31'd0, bus.busy}, 32'd0);
    endtask

    // One byte from a single requester through a normal UART, checking the strobe.
    task automatic send_one(input string tag, input bit id, input logic [7:0] d);
        tick();
        if (id) begin bus.req1_valid = 1'b1; bus.req1_data = d; end
        else    begin bus.req0_valid = 1'b1; bus.req0_data = d; end
        #1;
        chk({tag, "_ready"}, {30'd0, bus.req1_ready, bus.req0_ready}, id ? 32'd2 : 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk({tag, "_send"}, {23'd0, bus.tx_send, bus.grant_id, bus.tx_data}, {23'd0, 1'b1, id, d});
        m_last = id;
        wait_idle(tag, 40);
    endtask

    bit          v0, v1, acc0, acc1, r0, r1;
    logic [7:0]  d0, d1;
    int          w;
    xfer_t       x;
    logic [15:0] base;

    initial begin
        btnC_clr       = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.req0_data  = '0;
        bus.req1_data  = '0;
        m_last         = 1;
        #3;
        chk("rst_tx_send",    {31'd0, bus.tx_send},     32'd0);
        chk("rst_tx_data",    {24'd0, bus.tx_data},     32'd0);
        chk("rst_grant_id",   {31'd0, bus.grant_id},    32'd0);
        chk("rst_busy",       {31'd0, bus.busy},        32'd0);
        chk("rst_sent_count", {16'd0, bus.sent_count},  32'd0);
        chk("rst_timeout",    {31'd0, bus.timeout_err}, 32'd0);
        chk("rst_readies",    {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        repeat (2) tick();
        btnC_clr = 1'b0;

        // Single byte, valid kept high through SEND: no ready outside IDLE
        u_lat = 2;
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h41;
        #1;
        chk("t1_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        tick();
        #1;
        chk("t1_ready_send", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd0);
        chk("t1_send", {22'd0, bus.busy, bus.tx_send, bus.grant_id, bus.tx_data}, {22'd0, 1'b1, 1'b1, 1'b0, 8'h41});
        bus.req0_valid = 1'b0;
        wait_idle("t1", 20);
        chk("t1_count", {16'd0, bus.sent_count}, 32'd1);

        // Both valid from reset: strict alternation
        btnC_clr       = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_data  = 8'h41;
        bus.req1_data  = 8'h61;
        repeat (2) tick();
        sent_q.delete();
        btnC_clr = 1'b0;
        m_last   = 1;
        for (int n = 0; n < 200 && sent_q.size() < 4; n++) tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        chk("t2_nsent", {31'd0, sent_q.size() >= 4}, 32'd1);
        for (int i = 0; i < 4 && i < sent_q.size(); i++) begin
            w = winner(1'b1, 1'b1, m_last);
            x.id   = w[0];
            x.data = (w == 1) ? 8'h61 : 8'h41;
            chk($sformatf("t2_order%0d", i), {23'd0, sent_q[i]}, {23'd0, x});
            m_last = w;
        end
        wait_idle("t2", 40);

        // UART stalled while in SEND: no strobe until ready returns
        do_reset();
        u_hold = 1'b1;
        tick();
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'h5A;
        #1;
        chk("t3_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        tick();
        bus.req1_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            #1;
            chk("t3_stall", {22'd0, bus.busy, bus.tx_send, bus.grant_id, bus.tx_data}, {22'd0, 1'b1, 1'b0, 1'b1, 8'h5A});
            tick();
        end
        u_hold = 1'b0;
        @(negedge clk);
        #1;
        chk("t3_strobe", {23'd0, bus.tx_send, bus.tx_data}, {23'd0, 1'b1, 8'h5A});
        tick();
        wait_idle("t3", 20);
        chk("t3_count", {16'd0, bus.sent_count}, 32'd1);

        // UART never answers the strobe: abort after BUSY_TIMEOUT cycles in WAIT_BUSY
        do_reset();
        u_never = 1'b1;
        tick();
        bus.req0_valid = 1'b1;
        bus.req0_data  = 8'h33;
        #1;
        chk("t4_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        chk("t4_send", {31'd0, bus.tx_send}, 32'd1);
        for (int k = 1; k <= BUSY_TIMEOUT; k++) begin
            tick();
            #1;
            chk("t4_waiting", {30'd0, bus.busy, bus.timeout_err}, 32'd2);
        end
        tick();
        #1;
        chk("t4_abort", {14'd0, bus.sent_count, bus.busy, bus.timeout_err}, 32'd1);
        u_never = 1'b0;
        u_lat   = 3;
        send_one("t4_next", 1'b1, 8'h77);
        chk("t4_after", {15'd0, bus.sent_count, bus.timeout_err}, {15'd0, 16'd1, 1'b1});

        // Async reset during WAIT_DONE, then req1-only traffic
        u_lat = 6;
        tick();
        bus.req1_valid = 1'b1;
        bus.req1_data  = 8'hC3;
        #1;
        chk("t5_ready", {30'd0, bus.req1_ready, bus.req0_ready}, 32'd2);
        tick();
        bus.req1_valid = 1'b0;
        #1;
        chk("t5_send", {31'd0, bus.tx_send}, 32'd1);
        tick();
        tick();
        #1;
        chk("t5_in_done", {31'd0, bus.busy}, 32'd1);
        btnC_clr = 1'b1;
        #1;
        chk("t5_rst_data",  {23'd0, bus.tx_send, bus.tx_data}, 32'd0);
        chk("t5_rst_stat",  {13'd0, bus.sent_count, bus.grant_id, bus.busy, bus.timeout_err}, 32'd0);
        tick();
        btnC_clr = 1'b0;
        u_lat    = 1;
        m_last   = 1;
        for (int j = 0; j < 2; j++) begin
            send_one("t5_req1", 1'b1, 8'h10 + 8'(j));
            chk("t5_count", {16'd0, bus.sent_count}, j + 1);
        end

        // sent_count wrap
        do_reset();
        force dut.r_sent_count = 16'hFFFE;
        tick();
        release dut.r_sent_count;
        #1;
        base = 16'hFFFE;
        chk("t6_preset", {16'd0, bus.sent_count}, {16'd0, base});
        for (int j = 1; j <= 3; j++) begin
            send_one("t6_byte", 1'b0, 8'hA0 + 8'(j));
            chk("t6_count", {16'd0, bus.sent_count}, (32'(base) + j) % 65536);
        end

        // Randomized traffic against the transfer-level model
        do_reset();
        v0 = 1'b0; v1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
        d0 = 8'h00; d1 = 8'h00;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (acc0)       begin v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom); end
            else if (v0)    begin if ($urandom_range(0, 3) == 0) v0 = 1'b0; end
            else            begin v0 = 1'($urandom_range(0, 1)); d0 = 8'($urandom); end
            if (acc1)       begin v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom); end
            else if (v1)    begin if ($urandom_range(0, 3) == 0) v1 = 1'b0; end
            else            begin v1 = 1'($urandom_range(0, 1)); d1 = 8'($urandom); end
            u_lat          = $urandom_range(1, 4);
            bus.req0_valid = v0;
            bus.req0_data  = d0;
            bus.req1_valid = v1;
            bus.req1_data  = d1;
            #1;
            r0   = bus.req0_ready;
            r1   = bus.req1_ready;
            acc0 = 1'b0;
            acc1 = 1'b0;
            chk("rnd_ready_any", {31'd0, r0 | r1}, {31'd0, !bus.busy && (v0 || v1)});
            if (r0 || r1) begin
                w = winner(v0, v1, m_last);
                chk("rnd_one_ready", {31'd0, r0 && r1}, 32'd0);
                chk("rnd_winner", r1 ? 32'd1 : 32'd0, w);
                x.id   = w[0];
                x.data = (w == 1) ? d1 : d0;
                exp_q.push_back(x);
                m_last = w;
                acc0   = r0;
                acc1   = r1;
            end
        end
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        wait_idle("rnd", 40);
        chk("rnd_nsent", sent_q.size(), exp_q.size());
        chk("rnd_count", {16'd0, bus.sent_count}, exp_q.size() % 65536);
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            chk($sformatf("rnd_xfer%0d", i), {23'd0, sent_q[i]}, {23'd0, exp_q[i]});

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
